// File: rtl/spcore_mc.sv
// Multi-cycle SIMD lane core: register file, ALU with predicate, and a
// request/acknowledge memory port guarded by a timeout.
module spcore_mc #(
  parameter int DW      = 16,
  parameter int NREG    = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [$clog2(NREG)-1:0] x,
  input  logic [$clog2(NREG)-1:0] y,
  input  logic [$clog2(NREG)-1:0] z,
  input  logic [DW-1:0]           I,
  input  logic [3:0]              aluc,
  input  logic [1:0]              s2,
  input  logic                    reg_we,
  output logic                    P,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [DW-1:0]           mem_addr,
  output logic [DW-1:0]           mem_wdata,
  input  logic [DW-1:0]           mem_rdata,
  input  logic                    mem_ack,
  output logic                    busy,
  output logic                    err,
  input  logic [$clog2(NREG)-1:0] dbg_sel,
  output logic [DW-1:0]           dbg_data
);

  localparam int RW = $clog2(NREG);
  localparam int SW = $clog2(DW);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic {IDLE, MEM} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   rf_q [NREG];
  logic            P_q, P_d;
  logic            err_q, err_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [DW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [RW-1:0]   dst_q, dst_d;
  logic            ldwe_q, ldwe_d;

  logic [DW-1:0]   a, b, c;
  logic [DW-1:0]   alu_res;
  logic            alu_p;
  logic            alu_wr;
  logic            issue;
  logic            rf_we;
  logic [RW-1:0]   rf_idx;
  logic [DW-1:0]   rf_wd;

  assign a = rf_q[x];
  assign b = rf_q[y];
  assign c = rf_q[z];

  assign op_ready = en && (state_q == IDLE);
  assign issue    = op_valid && op_ready;

  always_comb begin
    alu_res = '0;
    alu_wr  = 1'b1;
    case (aluc)
      4'd0:    alu_res = a + b;
      4'd1:    alu_res = a - b;
      4'd2:    alu_res = a & b;
      4'd3:    alu_res = a | b;
      4'd4:    alu_res = a ^ b;
      4'd5:    alu_res = ~a;
      4'd6:    alu_res = a << b[SW-1:0];
      4'd7:    alu_res = a >> b[SW-1:0];
      4'd8:    alu_res = a * b + c;
      4'd9:    alu_res = {{(DW-1){1'b0}}, (a < b)};
      4'd10:   alu_res = {{(DW-1){1'b0}}, (a == b)};
      4'd11:   alu_res = a;
      default: alu_wr  = 1'b0;
    endcase
    // Compare opcodes expose their outcome directly; reserved opcodes leave P alone.
    if (aluc == 4'd9 || aluc == 4'd10) alu_p = alu_res[0];
    else if (alu_wr)                   alu_p = (alu_res == '0);
    else                               alu_p = P_q;
  end

  always_comb begin
    state_d = state_q;
    P_d     = P_q;
    err_d   = err_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    dst_d   = dst_q;
    ldwe_d  = ldwe_q;
    rf_we   = 1'b0;
    rf_idx  = x;
    rf_wd   = I;
    case (state_q)
      IDLE: begin
        if (issue) begin
          case (s2)
            2'b00: rf_we = reg_we;
            2'b10: begin
              rf_we = reg_we && alu_wr;
              rf_wd = alu_res;
              P_d   = alu_p;
            end
            default: begin
              addr_d  = b;
              wdata_d = a;
              we_d    = s2[1];
              req_d   = 1'b1;
              cnt_d   = '0;
              dst_d   = x;
              ldwe_d  = reg_we && !s2[1];
              state_d = MEM;
            end
          endcase
        end
      end
      MEM: begin
        // Acknowledge wins over timeout on the final allowed cycle.
        if (mem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
          if (ldwe_q) begin
            rf_we  = 1'b1;
            rf_idx = dst_q;
            rf_wd  = mem_rdata;
          end
        end else if (cnt_q == TO_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      P_q     <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      dst_q   <= '0;
      ldwe_q  <= 1'b0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      P_q     <= P_d;
      err_q   <= err_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      dst_q   <= dst_d;
      ldwe_q  <= ldwe_d;
      if (rf_we) rf_q[rf_idx] <= rf_wd;
    end
  end

  assign P         = P_q;
  assign err       = err_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign dbg_data  = rf_q[dbg_sel];

endmodule

// File: tb/tb_spcore_mc.sv
// Randomised bench for spcore_mc against an arithmetic reference model.
module tb_spcore_mc;

  localparam int DW      = 16;
  localparam int NREG    = 16;
  localparam int TIMEOUT = 6;
  localparam int RW      = 4;
  localparam longint M   = 64'hFFFF;

  logic            clk = 1'b0;
  logic            reset;
  logic            en;
  logic            op_valid;
  logic            op_ready;
  logic [RW-1:0]   x, y, z;
  logic [DW-1:0]   I;
  logic [3:0]      aluc;
  logic [1:0]      s2;
  logic            reg_we;
  logic            P;
  logic            mem_req, mem_we;
  logic [DW-1:0]   mem_addr, mem_wdata, mem_rdata;
  logic            mem_ack;
  logic            busy, err;
  logic [RW-1:0]   dbg_sel;
  logic [DW-1:0]   dbg_data;

  int vecs = 0;
  int errs = 0;

  logic [DW-1:0]   m_rf [NREG];
  logic            m_p;
  logic            m_err;

  spcore_mc #(.DW(DW), .NREG(NREG), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .en(en), .op_valid(op_valid), .op_ready(op_ready),
    .x(x), .y(y), .z(z), .I(I), .aluc(aluc), .s2(s2), .reg_we(reg_we), .P(P),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .err(err),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  function automatic void model_clear();
    for (int i = 0; i < NREG; i++) m_rf[i] = '0;
    m_p   = 1'b0;
    m_err = 1'b0;
  endfunction

  function automatic void model_alu(input logic [3:0] op, input logic [DW-1:0] a, b, c,
                                    input logic p_in, output logic [DW-1:0] res,
                                    output logic p_out, output logic wr);
    longint ua, ub, uc, r;
    ua = longint'(a); ub = longint'(b); uc = longint'(c);
    r = 0; wr = 1'b1; p_out = p_in;
    case (op)
      4'd0:    r = ua + ub;
      4'd1:    r = ua - ub;
      4'd2:    r = ua & ub;
      4'd3:    r = ua | ub;
      4'd4:    r = ua ^ ub;
      4'd5:    r = ~ua;
      4'd6:    r = ua << (ub % DW);
      4'd7:    r = ua >> (ub % DW);
      4'd8:    r = ua * ub + uc;
      4'd9:    r = (ua < ub) ? 1 : 0;
      4'd10:   r = (ua == ub) ? 1 : 0;
      4'd11:   r = ua;
      default: wr = 1'b0;
    endcase
    r = r & M;
    res = r[DW-1:0];
    if (op == 4'd9 || op == 4'd10) p_out = (r == 1);
    else if (wr)                   p_out = (r == 0);
  endfunction

  task automatic issue_op(input logic [1:0] cls, input logic [RW-1:0] xi, yi, zi,
                          input logic [DW-1:0] imm, input logic [3:0] op, input logic we);
    op_valid = 1'b1; s2 = cls; x = xi; y = yi; z = zi; I = imm; aluc = op; reg_we = we;
    @(posedge clk); @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic op_imm(input logic [RW-1:0] xi, input logic [DW-1:0] v, input logic we);
    issue_op(2'b00, xi, 4'd0, 4'd0, v, 4'd0, we);
    if (we) m_rf[xi] = v;
  endtask

  task automatic op_alu(input logic [RW-1:0] xi, yi, zi, input logic [3:0] op, input logic we);
    logic [DW-1:0] res;
    logic          np, wr;
    model_alu(op, m_rf[xi], m_rf[yi], m_rf[zi], m_p, res, np, wr);
    issue_op(2'b10, xi, yi, zi, 16'h0, op, we);
    m_p = np;
    if (we && wr) m_rf[xi] = res;
  endtask

  // delay k>=1: ack presented during the k-th cycle mem_req is high; k>TIMEOUT: never.
  task automatic op_mem(input string tag, input logic st, input logic [RW-1:0] xi, yi,
                        input logic we, input int delay, input logic [DW-1:0] rd,
                        input logic [RW-1:0] xw, input logic enw);
    logic [DW-1:0] ea, ed;
    logic [31:0]   r;
    int            done_k, exp_k;
    logic          acked;
    ea = m_rf[yi]; ed = m_rf[xi]; done_k = 0;
    issue_op(st ? 2'b11 : 2'b01, xi, yi, 4'd0, 16'h0, 4'd0, we);
    x = xw; en = enw;
    #1;
    vecs++;
    if (mem_req !== 1'b1 || mem_we !== st || mem_addr !== ea || mem_wdata !== ed ||
        busy !== 1'b1 || op_ready !== 1'b0) begin
      errs++;
      $display("FAIL %s_req: req=%b we=%b addr=%h wdata=%h busy=%b rdy=%b, want 1 %b %h %h 1 0",
               tag, mem_req, mem_we, mem_addr, mem_wdata, busy, op_ready, st, ea, ed);
    end
    for (int k = 1; k <= TIMEOUT + 2; k++) begin
      if (k == delay) begin mem_ack = 1'b1; mem_rdata = rd; end
      @(posedge clk); @(negedge clk);
      r = $urandom;
      mem_ack = 1'b0; mem_rdata = r[DW-1:0];
      if (mem_req !== 1'b1) begin done_k = k; break; end
      vecs++;
      if (mem_addr !== ea || mem_wdata !== ed || mem_we !== st) begin
        errs++;
        $display("FAIL %s_stable: addr=%h wdata=%h we=%b, want %h %h %b",
                 tag, mem_addr, mem_wdata, mem_we, ea, ed, st);
      end
    end
    acked = (delay >= 1 && delay <= TIMEOUT);
    exp_k = acked ? delay : TIMEOUT;
    if (acked && !st && we) m_rf[xi] = rd;
    if (!acked) m_err = 1'b1;
    vecs++;
    if (done_k != exp_k) begin
      errs++;
      $display("FAIL %s_reqlen: req high %0d cycles, want %0d", tag, done_k, exp_k);
    end
    #1;
    vecs++;
    if (busy !== 1'b0 || op_ready !== enw || err !== m_err) begin
      errs++;
      $display("FAIL %s_done: busy=%b rdy=%b err=%b, want 0 %b %b", tag, busy, op_ready, err, enw, m_err);
    end
    dbg_sel = xi; #1;
    vecs++;
    if (dbg_data !== m_rf[xi]) begin
      errs++;
      $display("FAIL %s_dst: R%0d=%h, want %h", tag, xi, dbg_data, m_rf[xi]);
    end
    dbg_sel = xw; #1;
    vecs++;
    if (dbg_data !== m_rf[xw]) begin
      errs++;
      $display("FAIL %s_xwait: R%0d=%h, want %h", tag, xw, dbg_data, m_rf[xw]);
    end
  endtask

  task automatic test_reset();
    op_imm(4'd1, 16'h1111, 1'b1);
    op_imm(4'd2, 16'h2222, 1'b1);
    issue_op(2'b11, 4'd1, 4'd2, 4'd0, 16'h0, 4'd0, 1'b0);
    #2 reset = 1'b0;
    #1;
    vecs++;
    if (mem_req !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL rst_abort: req=%b busy=%b, want 0 0", mem_req, busy);
    end
    @(negedge clk); reset = 1'b1;
    model_clear();
    for (int i = 0; i < NREG; i++) begin
      dbg_sel = RW'(i); #1;
      vecs++;
      if (dbg_data !== 16'h0000) begin
        errs++;
        $display("FAIL rst_reg: R%0d=%h, want 0000", i, dbg_data);
      end
    end
    vecs++;
    if (P !== 1'b0 || err !== 1'b0 || op_ready !== en || mem_req !== 1'b0 ||
        mem_addr !== 16'h0 || mem_wdata !== 16'h0 || mem_we !== 1'b0) begin
      errs++;
      $display("FAIL rst_ctl: P=%b err=%b rdy=%b req=%b addr=%h wd=%h we=%b, want all 0, rdy=%b",
               P, err, op_ready, mem_req, mem_addr, mem_wdata, mem_we, en);
    end
    op_imm(4'd3, 16'h1234, 1'b1);
    dbg_sel = 4'd3; #1;
    vecs++;
    if (dbg_data !== 16'h1234) begin
      errs++;
      $display("FAIL rst_imm: R3=%h, want 1234", dbg_data);
    end
  endtask

  task automatic test_imm();
    logic [31:0] r;
    for (int n = 0; n < 24; n++) begin
      r = $urandom;
      op_imm(r[3:0], r[31:16], r[4]);
      vecs++;
      if (op_ready !== 1'b1 || P !== m_p) begin
        errs++;
        $display("FAIL imm_ctl: rdy=%b P=%b, want 1 %b", op_ready, P, m_p);
      end
    end
    for (int i = 0; i < NREG; i++) begin
      dbg_sel = RW'(i); #1;
      vecs++;
      if (dbg_data !== m_rf[i]) begin
        errs++;
        $display("FAIL imm_reg: R%0d=%h, want %h", i, dbg_data, m_rf[i]);
      end
    end
  endtask

  task automatic test_alu();
    op_imm(4'd1, 16'hFFFF, 1'b1);
    op_imm(4'd2, 16'h0001, 1'b1);
    op_alu(4'd1, 4'd2, 4'd0, 4'd0, 1'b1);
    dbg_sel = 4'd1; #1;
    vecs++;
    if (dbg_data !== 16'h0000 || P !== 1'b1) begin
      errs++;
      $display("FAIL alu_add_wrap: R1=%h P=%b, want 0000 1", dbg_data, P);
    end
    op_imm(4'd1, 16'h0005, 1'b1);
    op_imm(4'd2, 16'h0007, 1'b1);
    op_alu(4'd1, 4'd2, 4'd0, 4'd9, 1'b1);
    #1;
    vecs++;
    if (dbg_data !== 16'h0001 || P !== 1'b1) begin
      errs++;
      $display("FAIL alu_lt: R1=%h P=%b, want 0001 1", dbg_data, P);
    end
    for (int op = 0; op < 16; op++) begin
      logic [31:0] r;
      r = $urandom;
      op_imm(r[3:0], r[31:16], 1'b1);
      op_alu(r[3:0], r[7:4], r[11:8], 4'(op), 1'b1);
      dbg_sel = r[3:0]; #1;
      vecs++;
      if (dbg_data !== m_rf[r[3:0]] || P !== m_p) begin
        errs++;
        $display("FAIL alu_op%0d: R%0d=%h P=%b, want %h %b", op, r[3:0], dbg_data, P, m_rf[r[3:0]], m_p);
      end
    end
  endtask

  task automatic test_store();
    op_imm(4'd4, 16'h00AA, 1'b1);
    op_imm(4'd5, 16'h0100, 1'b1);
    op_mem("store", 1'b1, 4'd4, 4'd5, 1'b1, 3, 16'h0000, 4'd4, 1'b1);
    vecs++;
    if (mem_req !== 1'b0) begin
      errs++;
      $display("FAIL store_reqlow: req=%b, want 0", mem_req);
    end
  endtask

  task automatic test_load();
    logic [DW-1:0] r2;
    r2 = m_rf[2];
    op_mem("load", 1'b0, 4'd6, 4'd5, 1'b1, 5, 16'hBEEF, 4'd2, 1'b1);
    dbg_sel = 4'd6; #1;
    vecs++;
    if (dbg_data !== 16'hBEEF) begin
      errs++;
      $display("FAIL load_r6: R6=%h, want beef", dbg_data);
    end
    dbg_sel = 4'd2; #1;
    vecs++;
    if (dbg_data !== r2) begin
      errs++;
      $display("FAIL load_r2: R2=%h, want %h", dbg_data, r2);
    end
    op_mem("load_nowe", 1'b0, 4'd7, 4'd5, 1'b0, 2, 16'h5A5A, 4'd7, 1'b1);
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    @(posedge clk); @(negedge clk);
    mem_ack = 1'b0;
    dbg_sel = 4'd6; #1;
    vecs++;
    if (busy !== 1'b0 || mem_req !== 1'b0 || dbg_data !== m_rf[6]) begin
      errs++;
      $display("FAIL stray_ack: busy=%b req=%b R6=%h, want 0 0 %h", busy, mem_req, dbg_data, m_rf[6]);
    end
  endtask

  task automatic test_timeout();
    op_imm(4'd8, 16'h7777, 1'b1);
    op_mem("timeout", 1'b0, 4'd8, 4'd5, 1'b1, TIMEOUT + 1, 16'h0, 4'd8, 1'b1);
    op_imm(4'd9, 16'h9999, 1'b1);
    dbg_sel = 4'd9; #1;
    vecs++;
    if (err !== 1'b1 || dbg_data !== 16'h9999) begin
      errs++;
      $display("FAIL err_sticky: err=%b R9=%h, want 1 9999", err, dbg_data);
    end
  endtask

  task automatic test_enable();
    en = 1'b0;
    op_valid = 1'b1; s2 = 2'b00; x = 4'd10; I = 16'h5555; reg_we = 1'b1;
    #1;
    vecs++;
    if (op_ready !== 1'b0) begin
      errs++;
      $display("FAIL en_ready: rdy=%b, want 0", op_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    dbg_sel = 4'd10; #1;
    vecs++;
    if (dbg_data !== m_rf[10] || busy !== 1'b0) begin
      errs++;
      $display("FAIL en_block: R10=%h busy=%b, want %h 0", dbg_data, busy, m_rf[10]);
    end
    en = 1'b1;
    op_mem("en_drop", 1'b0, 4'd11, 4'd5, 1'b1, 3, 16'hCAFE, 4'd11, 1'b0);
    en = 1'b1;
  endtask

  task automatic test_random_stream();
    logic [31:0] r, q;
    for (int n = 0; n < 200; n++) begin
      r = $urandom; q = $urandom;
      case (r[17:16])
        2'b00: op_imm(r[3:0], q[15:0], r[18]);
        2'b10: op_alu(r[3:0], r[7:4], r[11:8], r[15:12], r[18]);
        default: op_mem("rnd_mem", r[17], r[3:0], r[7:4], r[18],
                        int'($urandom_range(TIMEOUT + 1, 1)), q[15:0], q[19:16], 1'b1);
      endcase
      dbg_sel = r[3:0]; #1;
      vecs++;
      if (dbg_data !== m_rf[r[3:0]] || P !== m_p || err !== m_err) begin
        errs++;
        $display("FAIL rnd_%0d: R%0d=%h P=%b err=%b, want %h %b %b",
                 n, r[3:0], dbg_data, P, err, m_rf[r[3:0]], m_p, m_err);
      end
    end
    for (int i = 0; i < NREG; i++) begin
      dbg_sel = RW'(i); #1;
      vecs++;
      if (dbg_data !== m_rf[i]) begin
        errs++;
        $display("FAIL rnd_final: R%0d=%h, want %h", i, dbg_data, m_rf[i]);
      end
    end
  endtask

  task automatic test_final_reset();
    #1 reset = 1'b0;
    #1;
    vecs++;
    if (err !== 1'b0 || P !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL final_rst: err=%b P=%b busy=%b, want 0 0 0", err, P, busy);
    end
    @(negedge clk); reset = 1'b1;
    model_clear();
  endtask

  initial begin
    reset = 1'b0; en = 1'b1; op_valid = 1'b0; x = '0; y = '0; z = '0; I = '0;
    aluc = '0; s2 = '0; reg_we = 1'b0; mem_rdata = '0; mem_ack = 1'b0; dbg_sel = '0;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    test_reset();
    test_imm();
    test_alu();
    test_store();
    test_load();
    test_timeout();
    test_enable();
    test_random_stream();
    test_final_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/spcore_mc.md
Name: spcore_mc

Overview:
- Parametrised, multi-cycle successor to the single-cycle streaming-processor core used in the tinyGPU SIMD array.
- Holds an NREG x DW register file, an ALU with predicate output P, and an immediate/ALU/memory write-back select.
- Adds an issue handshake, a registered memory request/acknowledge interface with a timeout, a sticky error flag and a debug register read port.
- Sits one per lane under the GPU controller, which broadcasts decoded instructions to all lanes.

Parameters:
- DW, 16, data and address width in bits (>=8).
- NREG, 16, number of general registers (power of 2, >=4); RW = $clog2(NREG).
- TIMEOUT, 255, maximum cycles to wait for mem_ack before aborting (1..65535).

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  lane enable; gates instruction issue only (no clock gating).
- op_valid  in  1  instruction present on x/y/z/I/aluc/s2/reg_we.
- op_ready  out  1  core can accept an instruction: en && state==IDLE.
- x  in  RW  destination register, and source A.
- y  in  RW  source B; memory address register.
- z  in  RW  source C.
- I  in  DW  immediate.
- aluc  in  4  ALU opcode.
- s2  in  2  op class: 00 IMM, 01 LOAD, 10 ALU, 11 STORE.
- reg_we  in  1  enable register write-back for IMM/ALU/LOAD.
- P  out  1  registered predicate.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  1 = store, 0 = load; valid while mem_req is high.
- mem_addr  out  DW  R[y] captured at issue.
- mem_wdata  out  DW  R[x] captured at issue.
- mem_rdata  in  DW  load data, sampled on the mem_ack edge.
- mem_ack  in  1  completes the outstanding request.
- busy  out  1  state != IDLE.
- err  out  1  sticky timeout flag.
- dbg_sel  in  RW  debug register select.
- dbg_data  out  DW  combinational R[dbg_sel].

Behaviour:
- Reset (asynchronous, when reset=0):
  - All registers, P, err, mem_req, mem_we, mem_addr, mem_wdata and the timeout counter clear to 0.
  - State goes to IDLE.
  - Reset asserted mid-transaction aborts it; mem_req drops immediately and no write-back occurs.
- Issue: an instruction issues on a rising edge where op_valid && op_ready. Operands are read combinationally: A=R[x], B=R[y], C=R[z].
- IMM: if reg_we, R[x] <= I at the issue edge. P is unchanged. The core stays in IDLE, giving 1 op/cycle throughput.
- ALU: if reg_we, R[x] <= result at the issue edge.
  - P <= (result==0) for opcodes 0-8 and 11.
  - P <= the comparison result for opcodes 9 and 10.
  - All arithmetic is modulo 2^DW and unsigned.
- ALU opcodes:
  - 0 A+B; 1 A-B; 2 A&B; 3 A|B; 4 A^B; 5 ~A.
  - 6 A<<B[log2DW-1:0]; 7 A>>B[log2DW-1:0] (logical).
  - 8 low DW bits of A*B+C.
  - 9 LT: P=(A<B), result={0..,P}.
  - 10 EQ: P=(A==B), result={0..,P}.
  - 11 MOV: result=A.
  - 12-15: result=0, P unchanged, no register write.
- LOAD/STORE at the issue edge:
  - mem_addr<=R[y], mem_wdata<=R[x], mem_we<=(s2==11), mem_req<=1, counter<=0.
  - State goes to MEM; mem_req first appears the cycle after issue.
- MEM state:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable.
  - On an edge with mem_ack=1: mem_req<=0 and state<=IDLE. For a LOAD with reg_we=1, R[x_latched]<=mem_rdata at that edge.
  - Otherwise the counter increments. On the edge where counter==TIMEOUT-1 without ack: mem_req<=0, err<=1, state<=IDLE, no write-back.
- Latched fields: destination index and reg_we are latched at issue; later x changes do not redirect write-back.
- mem_ack while mem_req=0 is ignored.
- en=0 blocks new issue. An in-flight MEM transaction still completes or times out.
- err is sticky until reset and does not block issue.
- dbg_data reflects register writes the cycle after the write edge.

Test Plan:
- Reset low mid-stream, release -> all dbg_data reads 0, P=0, err=0, op_ready=en. Then IMM x=3 I=0x1234 reg_we=1 -> dbg_sel=3 reads 0x1234 next cycle.
- R1=0xFFFF, R2=0x0001, ALU aluc=0 x=1 y=2 -> R1=0x0000, P=1. Then aluc=9 with A=5, B=7 -> P=1, R1=0x0001.
- R4=0x00AA, R5=0x0100, STORE x=4 y=5 -> mem_req rises next cycle with addr=0x0100, wdata=0x00AA, we=1. op_ready=0 until ack at cycle 3; mem_req low after the ack edge.
- LOAD x=6 y=5 with rdata=0xBEEF, ack after 5 cycles; x changed to 2 during the wait -> R6=0xBEEF, R2 untouched, busy low the cycle after ack.
- TIMEOUT=4, LOAD with no ack -> mem_req high exactly 4 cycles, err=1, destination unchanged, op_ready returns. err stays 1 until reset.
- en=0 with op_valid=1 -> no register change, op_ready=0. en drops during MEM -> ack still writes back.
